// File: rtl/spiking_systolic_array_param.sv
// ============================================================================
// spiking_systolic_array_param
//
// ROWS x COLS output-stationary spiking systolic array. Each accepted input
// beat carries one spike bit per row and one signed weight per column. The
// operands are staggered by skew pipelines. PE(i,j) adds weight j into its
// accumulator whenever row i's spike arrives together with a valid weight.
// A small control FSM (IDLE -> LOAD -> FLUSH -> DONE) collects a tile and
// drains the array. It then holds the results until the writeback side takes
// them.
//
// Handshake rule, both sides: a transfer happens on a rising edge where valid
// and ready are both 1. The producer holds valid and its payload until that
// edge. While out_valid is high, out_data and ovf do not change.
//
// Optional feature: define SPIKING_SSA_SAT_EN to make the accumulators
// saturate at the signed ACC_WIDTH limits. When the macro is not defined,
// the accumulators wrap in two's complement. In both builds ovf reports any
// signed overflow in the current tile.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rstn       synchronous active-low reset
//   in_valid   input beat valid
//   in_ready   array accepts a beat (IDLE/LOAD only)
//   in_last    final beat of the tile
//   in_spikes  bit i = spike for row i
//   in_weights slice j = signed weight for column j
//   out_valid  tile result available and held stable
//   out_ready  writeback consumes the result
//   out_data   PE(i,j) accumulator at [(i*COLS+j)*ACC_WIDTH +: ACC_WIDTH]
//   ovf        sticky overflow flag for the current tile
//   dbg_state  current FSM state (0 IDLE, 1 LOAD, 2 FLUSH, 3 DONE)
// ============================================================================
module spiking_systolic_array_param #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    input  logic [ROWS-1:0]                 in_spikes,
    input  logic [COLS*DATA_WIDTH-1:0]      in_weights,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ROWS*COLS*ACC_WIDTH-1:0]  out_data,
    output logic                            ovf,
    output logic [1:0]                      dbg_state
);

    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int CW        = $clog2(ROWS + COLS) + 1;

`ifdef SPIKING_SSA_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_ovf;
    logic [CW-1:0]          r_cnt;

    logic                   w_accept;
    logic                   w_clear;
    logic [ROWS-1:0]        w_spk_in;
    logic [ROWS-1:0]        w_row_feed;
    logic [COLS*(DATA_WIDTH+1)-1:0] w_col_feed;
    logic [ROWS*COLS-1:0]   w_pe_ovf;

    assign w_accept  = in_valid & r_in_ready;
    // The result is consumed only in DONE; out_ready in other states is ignored.
    assign w_clear   = (r_state == S_DONE) & out_ready;
    // A bubble or an idle cycle enters the pipes as spike=0 and valid=0.
    assign w_spk_in  = in_spikes & {ROWS{w_accept}};

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

    // ------------------------------------------------------------------
    // Control FSM. in_ready and out_valid are registered and follow the
    // next state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (in_last) begin
                            r_state    <= S_FLUSH;
                            r_in_ready <= 1'b0;
                            r_cnt      <= '0;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_FLUSH: begin
                    // The last PE updates FLUSH_LEN edges after the last beat.
                    // DONE is entered on the edge after that update.
                    if (r_cnt == CW'(FLUSH_LEN)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Sticky tile overflow: OR of every PE's overflow, cleared with the tile.
    always_ff @(posedge clk) begin
        if (!rstn || w_clear) r_ovf <= 1'b0;
        else                  r_ovf <= r_ovf | (|w_pe_ovf);
    end

    // ------------------------------------------------------------------
    // Row skew: row i's spike is delayed by i registers.
    // ------------------------------------------------------------------
    genvar gi, gj;
    for (gi = 0; gi < ROWS; gi++) begin : g_row_skew
        if (gi == 0) begin : g_direct
            assign w_row_feed[gi] = w_spk_in[gi];
        end else begin : g_delay
            logic [gi-1:0] r_chain;
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_chain <= '0;
                end else begin
                    r_chain[0] <= w_spk_in[gi];
                    for (int k = 1; k < gi; k++) r_chain[k] <= r_chain[k-1];
                end
            end
            assign w_row_feed[gi] = r_chain[gi-1];
        end
    end

    // ------------------------------------------------------------------
    // Column skew: {valid, weight} for column j is delayed by j registers.
    // ------------------------------------------------------------------
    for (gj = 0; gj < COLS; gj++) begin : g_col_skew
        if (gj == 0) begin : g_direct
            assign w_col_feed[gj*(DATA_WIDTH+1) +: DATA_WIDTH+1] =
                {w_accept, in_weights[gj*DATA_WIDTH +: DATA_WIDTH]};
        end else begin : g_delay
            logic [DATA_WIDTH:0] r_chain [gj];
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int k = 0; k < gj; k++) r_chain[k] <= '0;
                end else begin
                    r_chain[0] <= {w_accept, in_weights[gj*DATA_WIDTH +: DATA_WIDTH]};
                    for (int k = 1; k < gj; k++) r_chain[k] <= r_chain[k-1];
                end
            end
            assign w_col_feed[gj*(DATA_WIDTH+1) +: DATA_WIDTH+1] = r_chain[gj-1];
        end
    end

    // ------------------------------------------------------------------
    // PE grid. Each PE registers its operands. Its right-hand neighbour reads
    // the spike register and the PE below reads the weight register. The
    // total operand delay is i+j+1 edges on both paths.
    // ------------------------------------------------------------------
    for (gi = 0; gi < ROWS; gi++) begin : g_pe_row
        for (gj = 0; gj < COLS; gj++) begin : g_pe_col
            logic                         w_spk_d;
            logic [DATA_WIDTH:0]          w_wt_d;
            logic                         r_spk;
            logic [DATA_WIDTH:0]          r_wt;
            logic signed [ACC_WIDTH-1:0]  r_acc;
            logic signed [DATA_WIDTH-1:0] w_w;
            logic signed [ACC_WIDTH-1:0]  w_ext;
            logic signed [ACC_WIDTH-1:0]  w_sum;
            logic signed [ACC_WIDTH-1:0]  w_next;
            logic                         w_hit;
            logic                         w_ov;

            if (gj == 0) begin : g_spk_edge
                assign w_spk_d = w_row_feed[gi];
            end else begin : g_spk_link
                assign w_spk_d = g_pe_row[gi].g_pe_col[gj-1].r_spk;
            end

            if (gi == 0) begin : g_wt_edge
                assign w_wt_d = w_col_feed[gj*(DATA_WIDTH+1) +: DATA_WIDTH+1];
            end else begin : g_wt_link
                assign w_wt_d = g_pe_row[gi-1].g_pe_col[gj].r_wt;
            end

            assign w_hit = r_spk & r_wt[DATA_WIDTH];
            assign w_w   = r_wt[DATA_WIDTH-1:0];
            assign w_ext = ACC_WIDTH'(w_w);
            assign w_sum = r_acc + w_ext;
            // Overflow: the operands have the same sign and the sum has the other sign.
            assign w_ov  = w_hit & (r_acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1])
                                 & (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

`ifdef SPIKING_SSA_SAT_EN
            // Clamp toward the sign of the operands that overflowed.
            assign w_next = w_ov ? (r_acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : w_sum;
`else
            assign w_next = w_sum;
`endif

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_spk <= 1'b0;
                    r_wt  <= '0;
                end else begin
                    r_spk <= w_spk_d;
                    r_wt  <= w_wt_d;
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn || w_clear) r_acc <= '0;
                else if (w_hit)       r_acc <= w_next;
            end

            assign w_pe_ovf[gi*COLS+gj] = w_ov;
            assign out_data[(gi*COLS+gj)*ACC_WIDTH +: ACC_WIDTH] = r_acc;
        end
    end

endmodule

// File: tb/tb_spiking_systolic_array_param.sv
module tb_spiking_systolic_array_param;

    // ---------------- clock / reset / shared buses ----------------
    logic         clk;
    logic         rstn;
    logic [2:0]   in_valid_v;
    logic [2:0]   out_ready_v;
    logic [2:0]   in_ready_v;
    logic [2:0]   out_valid_v;
    logic [2:0]   ovf_v;
    logic         bus_last;
    logic [7:0]   bus_spk;
    logic [159:0] bus_wt;
    logic [4*4*24-1:0] a_data;
    logic [4*4*16-1:0] b_data;
    logic [2*5*24-1:0] c_data;
    logic [1:0]   a_dbg, b_dbg, c_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_edge = 0;

    // instance table: 0 = 4x4 acc24, 1 = 4x4 acc16, 2 = 2x5 acc24
    int rows_t [3] = '{4, 4, 2};
    int cols_t [3] = '{4, 4, 5};
    int aw_t   [3] = '{24, 16, 24};

    // reference model state
    logic [7:0]   q_spk [$];
    logic [159:0] q_wt  [$];
    longint       exp_acc [8][8];
    logic         exp_ovf;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    spiking_systolic_array_param #(.ROWS(4), .COLS(4), .DATA_WIDTH(16), .ACC_WIDTH(24)) u_a (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_last(bus_last), .in_spikes(bus_spk[3:0]), .in_weights(bus_wt[63:0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_data(a_data),
        .ovf(ovf_v[0]), .dbg_state(a_dbg));

    spiking_systolic_array_param #(.ROWS(4), .COLS(4), .DATA_WIDTH(16), .ACC_WIDTH(16)) u_b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_last(bus_last), .in_spikes(bus_spk[3:0]), .in_weights(bus_wt[63:0]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_data(b_data),
        .ovf(ovf_v[1]), .dbg_state(b_dbg));

    spiking_systolic_array_param #(.ROWS(2), .COLS(5), .DATA_WIDTH(16), .ACC_WIDTH(24)) u_c (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_last(bus_last), .in_spikes(bus_spk[1:0]), .in_weights(bus_wt[79:0]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_data(c_data),
        .ovf(ovf_v[2]), .dbg_state(c_dbg));

    // ---------------- reference model ----------------
    // Sums each row's spiking weights beat by beat in plain integer arithmetic.
    // The sum is then saturated or wrapped at the signed accumulator range.
    function automatic void run_model(input int s);
        longint hi, lo, w, v;
        logic [159:0] wv;
        hi = (longint'(1) <<< (aw_t[s] - 1)) - 1;
        lo = -hi - 1;
        exp_ovf = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) exp_acc[i][j] = 0;
        foreach (q_spk[b]) begin
            wv = q_wt[b];
            for (int i = 0; i < rows_t[s]; i++) begin
                if (q_spk[b][i]) begin
                    for (int j = 0; j < cols_t[s]; j++) begin
                        w = longint'($signed(wv[j*16 +: 16]));
                        v = exp_acc[i][j] + w;
                        if (v > hi || v < lo) begin
                            exp_ovf = 1'b1;
`ifdef SPIKING_SSA_SAT_EN
                            v = (v > hi) ? hi : lo;
`else
                            v = (v > hi) ? v - 2 * (hi + 1) : v + 2 * (hi + 1);
`endif
                        end
                        exp_acc[i][j] = v;
                    end
                end
            end
        end
    endfunction

    function automatic longint get_pe(input int s, input int i, input int j);
        case (s)
            0:       return longint'($signed(a_data[(i*4+j)*24 +: 24]));
            1:       return longint'($signed(b_data[(i*4+j)*16 +: 16]));
            default: return longint'($signed(c_data[(i*5+j)*24 +: 24]));
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int s, input logic [7:0] spk, input logic [159:0] wt, input logic last);
        bus_spk = spk;
        bus_wt = wt;
        bus_last = last;
        in_valid_v[s] = 1'b1;
        n_checks++;
        if (in_ready_v[s] !== 1'b1) begin
            n_errors++;
            $display("FAIL beat_ready inst%0d: in_ready=%b required 1", s, in_ready_v[s]);
        end
        @(posedge clk);
        #1;
        in_valid_v[s] = 1'b0;
        q_spk.push_back(spk);
        q_wt.push_back(wt);
        last_edge = cyc;
    endtask

    task automatic finish_tile(input int s, input string name, input int exp_lat);
        int k, lat, bad, bi, bj;
        longint bg;
        run_model(s);
        k = 0;
        while (out_valid_v[s] !== 1'b1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        lat = cyc - last_edge;
        n_checks++;
        if (out_valid_v[s] !== 1'b1) begin
            n_errors++;
            $display("FAIL %s out_valid: timed out after %0d cycles, required rise after %0d", name, k, exp_lat);
        end else if (lat != exp_lat) begin
            n_errors++;
            $display("FAIL %s latency: out_valid after %0d cycles, required %0d", name, lat, exp_lat);
        end
        bad = 0; bi = 0; bj = 0; bg = 0;
        for (int i = 0; i < rows_t[s]; i++)
            for (int j = 0; j < cols_t[s]; j++)
                if (get_pe(s, i, j) !== exp_acc[i][j]) begin
                    if (bad == 0) begin bi = i; bj = j; bg = get_pe(s, i, j); end
                    bad++;
                end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL %s data: PE(%0d,%0d)=%0d required %0d (%0d PEs wrong)", name, bi, bj, bg, exp_acc[bi][bj], bad);
        end
        n_checks++;
        if (ovf_v[s] !== exp_ovf) begin
            n_errors++;
            $display("FAIL %s ovf: got %b required %b", name, ovf_v[s], exp_ovf);
        end
        n_checks++;
        if (in_ready_v[s] !== 1'b0) begin
            n_errors++;
            $display("FAIL %s in_ready_done: got %b required 0", name, in_ready_v[s]);
        end
    endtask

    task automatic consume(input int s, input string name);
        int bad;
        out_ready_v[s] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[s] = 1'b0;
        n_checks++;
        if (out_valid_v[s] !== 1'b0 || in_ready_v[s] !== 1'b1 || ovf_v[s] !== 1'b0) begin
            n_errors++;
            $display("FAIL %s consume: out_valid=%b in_ready=%b ovf=%b required 0/1/0",
                     name, out_valid_v[s], in_ready_v[s], ovf_v[s]);
        end
        bad = 0;
        for (int i = 0; i < rows_t[s]; i++)
            for (int j = 0; j < cols_t[s]; j++)
                if (get_pe(s, i, j) !== 0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL %s cleared: %0d PEs nonzero after consume, required 0", name, bad);
        end
    endtask

    task automatic random_tile(input int s, input string name);
        int n;
        logic [159:0] wt;
        logic [7:0] spk;
        q_spk.delete();
        q_wt.delete();
        n = $urandom_range(1, 6);
        for (int b = 0; b < n; b++) begin
            if (b > 0) idle($urandom_range(0, 2));
            spk = 8'($urandom);
            for (int w = 0; w < 5; w++) wt[w*32 +: 32] = $urandom;
            send(s, spk, wt, (b == n - 1));
        end
        finish_tile(s, name, rows_t[s] + cols_t[s]);
        consume(s, name);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [159:0] wt;
        rstn = 1'b0;
        in_valid_v = '0;
        out_ready_v = '0;
        bus_last = 1'b0;
        bus_spk = '0;
        bus_wt = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready_v !== 3'b000 || out_valid_v !== 3'b000 || ovf_v !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b ovf=%b required 000/000/000", in_ready_v, out_valid_v, ovf_v);
        end
        n_checks++;
        if (a_data !== '0 || b_data !== '0 || c_data !== '0) begin
            n_errors++;
            $display("FAIL reset_data: out_data not zero (a=%h) required 0", a_data);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready_v !== 3'b111) begin
            n_errors++;
            $display("FAIL reset_release: in_ready=%b required 111", in_ready_v);
        end
        // abort a tile in the middle of LOAD
        q_spk.delete();
        q_wt.delete();
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 5; w++) wt[w*32 +: 32] = $urandom;
            send(0, 8'hFF, wt, 1'b0);
        end
        idle(1);
        rstn = 1'b0;
        idle(2);
        n_checks++;
        if (in_ready_v[0] !== 1'b0 || out_valid_v[0] !== 1'b0 || ovf_v[0] !== 1'b0 || a_data !== '0) begin
            n_errors++;
            $display("FAIL midreset: in_ready=%b out_valid=%b ovf=%b data_zero=%b required 0/0/0/1",
                     in_ready_v[0], out_valid_v[0], ovf_v[0], (a_data == '0));
        end
        rstn = 1'b1;
        idle(1);
        n_checks++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_release: in_ready=%b out_valid=%b required 1/0", in_ready_v[0], out_valid_v[0]);
        end
        q_spk.delete();
        q_wt.delete();
        for (int w = 0; w < 5; w++) wt[w*32 +: 32] = $urandom;
        send(0, 8'($urandom), wt, 1'b1);
        finish_tile(0, "after_reset", 8);
        consume(0, "after_reset");
    endtask

    task automatic test_identity();
        logic [159:0] wt;
        q_spk.delete();
        q_wt.delete();
        for (int k = 0; k < 4; k++) begin
            wt = '0;
            for (int j = 0; j < 4; j++) wt[j*16 +: 16] = 16'(k + 1);
            send(0, 8'(1 << k), wt, (k == 3));
        end
        finish_tile(0, "identity", 8);
        n_checks++;
        if (get_pe(0, 2, 3) !== 3 || get_pe(0, 0, 1) !== 1) begin
            n_errors++;
            $display("FAIL identity_const: PE(2,3)=%0d PE(0,1)=%0d required 3/1", get_pe(0, 2, 3), get_pe(0, 0, 1));
        end
        consume(0, "identity");
    endtask

    task automatic test_bubbles();
        q_spk.delete();
        q_wt.delete();
        out_ready_v[0] = 1'b1;  // must be ignored outside DONE
        send(0, 8'h0F, {10{16'hFFFD}}, 1'b0);
        idle(3);
        send(0, 8'h05, {10{16'h0007}}, 1'b1);
        finish_tile(0, "bubbles", 8);
        n_checks++;
        if (get_pe(0, 0, 0) !== 4 || get_pe(0, 3, 2) !== -3) begin
            n_errors++;
            $display("FAIL bubbles_const: PE(0,0)=%0d PE(3,2)=%0d required 4/-3", get_pe(0, 0, 0), get_pe(0, 3, 2));
        end
        consume(0, "bubbles");
    endtask

    task automatic test_backpressure();
        int bad;
        logic [159:0] wt;
        q_spk.delete();
        q_wt.delete();
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 5; w++) wt[w*32 +: 32] = $urandom;
            send(0, 8'($urandom), wt, (b == 1));
        end
        finish_tile(0, "backpressure", 8);
        for (int c = 0; c < 10; c++) begin
            idle(1);
            bad = 0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    if (get_pe(0, i, j) !== exp_acc[i][j]) bad++;
            n_checks++;
            if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || ovf_v[0] !== exp_ovf || bad != 0) begin
                n_errors++;
                $display("FAIL hold cycle %0d: out_valid=%b in_ready=%b ovf=%b wrong_pes=%0d required 1/0/%b/0",
                         c, out_valid_v[0], in_ready_v[0], ovf_v[0], bad, exp_ovf);
            end
        end
        consume(0, "backpressure");
        random_tile(0, "after_backpressure");
    endtask

    task automatic test_back_to_back();
        logic [159:0] wt;
        for (int t = 0; t < 2; t++) begin
            q_spk.delete();
            q_wt.delete();
            for (int b = 0; b < 3; b++) begin
                for (int w = 0; w < 5; w++) wt[w*32 +: 32] = $urandom;
                send(0, 8'($urandom), wt, (b == 2));
            end
            // junk beats offered during FLUSH/DONE must be ignored
            bus_spk = 8'hFF;
            bus_wt = {5{32'h1234_5678}};
            bus_last = 1'b1;
            in_valid_v[0] = 1'b1;
            finish_tile(0, "back_to_back", 8);
            in_valid_v[0] = 1'b0;
            consume(0, "back_to_back");
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 3; s++) random_tile(s, "random");
    endtask

    task automatic test_overflow();
        q_spk.delete();
        q_wt.delete();
        for (int b = 0; b < 3; b++) send(1, 8'h0F, {10{16'h7FFF}}, (b == 2));
        finish_tile(1, "overflow", 8);
        n_checks++;
`ifdef SPIKING_SSA_SAT_EN
        if (get_pe(1, 3, 3) !== 32767 || ovf_v[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_const: PE(3,3)=%0d ovf=%b required 32767/1", get_pe(1, 3, 3), ovf_v[1]);
        end
`else
        if (get_pe(1, 3, 3) !== 32765 || ovf_v[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_const: PE(3,3)=%0d ovf=%b required 32765/1", get_pe(1, 3, 3), ovf_v[1]);
        end
`endif
        consume(1, "overflow");
        random_tile(1, "overflow_random");
    endtask

    task automatic test_nonsquare();
        logic [159:0] wt;
        q_spk.delete();
        q_wt.delete();
        wt = '0;
        for (int j = 0; j < 5; j++) wt[j*16 +: 16] = 16'(j + 1);
        send(2, 8'h02, wt, 1'b1);
        finish_tile(2, "nonsquare", 7);
        n_checks++;
        if (get_pe(2, 1, 4) !== 5 || get_pe(2, 0, 4) !== 0) begin
            n_errors++;
            $display("FAIL nonsquare_const: PE(1,4)=%0d PE(0,4)=%0d required 5/0", get_pe(2, 1, 4), get_pe(2, 0, 4));
        end
        consume(2, "nonsquare");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_bubbles();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_nonsquare();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the run completed");
        $fatal(1, "watchdog");
    end

endmodule
